// File: rtl/sbox_inv_engine.sv
// Iterative AES inverse S-box: InvAffine on capture, then x^254 in GF(2^8) over 8 cycles
// (square-and-multiply, exponent scanned MSB first). Counts completed output handshakes.
module sbox_inv_engine #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       data_out,
    output logic             busy,
    output logic [CNT_W-1:0] byte_cnt
);

    // 254 = 0b1111_1110; bit [step_q] selects whether this cycle also multiplies by x
    localparam logic [7:0] Exponent    = 8'hFE;
    localparam logic [7:0] AffineConst = 8'h05;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [7:0]       x_q, x_d;
    logic [7:0]       acc_q, acc_d;
    logic [2:0]       step_q, step_d;
    logic [7:0]       data_out_q, data_out_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic [7:0] acc_sq;
    logic [7:0] acc_step;

    // GF(2^8) multiply, reduced by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ AffineConst[i];
        end
        return r;
    endfunction

    assign acc_sq   = gf_mul(acc_q, acc_q);
    assign acc_step = Exponent[step_q] ? gf_mul(acc_sq, x_q) : acc_sq;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StCalc;
            StCalc: if (step_q == 3'd0) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; in_ready is held low for as long as reset is asserted
    always_comb begin
        in_ready  = rst && (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    // Datapath next-state: capture, square-and-multiply steps, output count
    always_comb begin
        x_d        = x_q;
        acc_d      = acc_q;
        step_d     = step_q;
        data_out_d = data_out_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d    = inv_affine(data_in);
                    acc_d  = 8'h01;
                    step_d = 3'd7;
                end
            end
            StCalc: begin
                acc_d  = acc_step;
                step_d = step_q - 3'd1;
                if (step_q == 3'd0) data_out_d = acc_step;
            end
            StDone: begin
                if (out_ready) byte_cnt_d = byte_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q        <= 8'h00;
            acc_q      <= 8'h00;
            step_q     <= 3'd0;
            data_out_q <= 8'h00;
            byte_cnt_q <= '0;
        end else begin
            x_q        <= x_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            data_out_q <= data_out_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign byte_cnt = byte_cnt_q;

endmodule
